// File: rtl/usb_dppl_cdr.sv
// Purpose : oversampling DPLL / clock-data recovery for the USB receive path.
// Latency : rxd -> rs is SYNC_STAGES cycles; rx_valid/rx_bit appear 3 cycles after the synced edge (OVERSAMPLE=4).
// Backpr. : none; the line cannot be stalled, so one strobe is emitted per recovered bit with no rdy input.
//
// Ports
//   clk48      sampling clock, OVERSAMPLE x bit rate
//   RST        synchronous active-high reset
//   rxd        async differential receiver output
//   dp_i/dn_i  async single-ended D+/D- (SE0 detection only)
//   rx_bit     sampled line level (J=1, K=0), valid with rx_valid
//   rx_valid   one-cycle strobe per recovered bit
//   rx_se0     se0 captured at the sample point, valid with rx_valid
//   se0        filtered live SE0 indication
//   locked     phase tracking stable
//   phase_err  one-cycle pulse when an edge lands on the sample point
//
// Optional feature: define USB_DPPL_SE0_DETECT_EN to build the SE0 detector.
// Without it se0/rx_se0 are tied low and dp_i/dn_i are ignored.

module usb_dppl_cdr #(
    parameter int OVERSAMPLE  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_EDGES  = 4,
    parameter int IDLE_BITS   = 8
) (
    input  logic clk48,
    input  logic RST,
    input  logic rxd,
    input  logic dp_i,
    input  logic dn_i,
    output logic rx_bit,
    output logic rx_valid,
    output logic rx_se0,
    output logic se0,
    output logic locked,
    output logic phase_err
);

    localparam int CW        = $clog2(OVERSAMPLE);
    localparam int LW        = $clog2(LOCK_EDGES + 1);
    localparam int IW        = $clog2(IDLE_BITS + 1);
    localparam int SAMPLE_PT = OVERSAMPLE / 2;

    localparam logic [CW-1:0] SP   = CW'(SAMPLE_PT);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic {
        IDLE,
        TRACK
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] rxd_sync;
    logic                   rs, rp;
    logic                   line_edge;
    logic                   in_win;
    logic                   sample_now;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [LW-1:0]          lock_cnt, lock_nxt, lock_inc;
    logic [IW-1:0]          idle_cnt, idle_nxt;
    logic                   locked_nxt;
    logic                   perr_nxt;

    assign rs = rxd_sync[SYNC_STAGES-1];

    // Transitions are ignored during SE0 so the phase is not dragged around
    // by EOP noise; se0 is a constant 0 when the detector is not built.
    assign line_edge = (rs ^ rp) & ~se0;

    // cnt sits at 0 in IDLE, so the first edge of a packet is in-window.
    assign in_win = (cnt == LAST) || (cnt == '0) || (cnt == CW'(1));

    assign sample_now = (state == TRACK) && (cnt == SP) && !line_edge;

    assign lock_inc = (lock_cnt == LW'(LOCK_EDGES)) ? lock_cnt : lock_cnt + LW'(1);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        lock_nxt   = lock_cnt;
        idle_nxt   = idle_cnt;
        locked_nxt = locked;
        perr_nxt   = 1'b0;

        if (line_edge) begin
            if (in_win) begin
                lock_nxt = lock_inc;
                if (lock_inc == LW'(LOCK_EDGES)) begin
                    locked_nxt = 1'b1;
                end
            end else begin
                lock_nxt   = '0;
                locked_nxt = 1'b0;
            end
        end

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (line_edge) begin
                    cnt_nxt   = CW'(1);
                    idle_nxt  = '0;
                    state_nxt = TRACK;
                end
            end
            TRACK: begin
                if (line_edge) begin
                    // The edge cycle is phase 0; an edge on the sample
                    // point is a hard realign and flags the phase error.
                    cnt_nxt  = CW'(1);
                    idle_nxt = '0;
                    perr_nxt = (cnt == SP);
                end else if (cnt == LAST) begin
                    cnt_nxt = '0;
                    if ((idle_cnt + IW'(1)) == IW'(IDLE_BITS)) begin
                        state_nxt  = IDLE;
                        idle_nxt   = '0;
                        lock_nxt   = '0;
                        locked_nxt = 1'b0;
                    end else begin
                        idle_nxt = idle_cnt + IW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk48) begin
        if (RST) begin
            rxd_sync  <= '0;
            rp        <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            lock_cnt  <= '0;
            idle_cnt  <= '0;
            locked    <= 1'b0;
            phase_err <= 1'b0;
            rx_valid  <= 1'b0;
            rx_bit    <= 1'b0;
        end else begin
            rxd_sync  <= {rxd_sync[SYNC_STAGES-2:0], rxd};
            rp        <= rs;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lock_cnt  <= lock_nxt;
            idle_cnt  <= idle_nxt;
            locked    <= locked_nxt;
            phase_err <= perr_nxt;
            rx_valid  <= sample_now;
            if (sample_now) begin
                rx_bit <= rs;
            end
        end
    end

`ifdef USB_DPPL_SE0_DETECT_EN
    logic [SYNC_STAGES-1:0] dp_sync, dn_sync;
    logic                   se0_lo, se0_lo_d;

    assign se0_lo = ~dp_sync[SYNC_STAGES-1] & ~dn_sync[SYNC_STAGES-1];

    // Two consecutive low samples are needed to raise se0; a single high
    // sample on either line drops it again.
    always_ff @(posedge clk48) begin
        if (RST) begin
            dp_sync  <= '0;
            dn_sync  <= '0;
            se0_lo_d <= 1'b0;
            se0      <= 1'b0;
            rx_se0   <= 1'b0;
        end else begin
            dp_sync  <= {dp_sync[SYNC_STAGES-2:0], dp_i};
            dn_sync  <= {dn_sync[SYNC_STAGES-2:0], dn_i};
            se0_lo_d <= se0_lo;
            se0      <= se0_lo & se0_lo_d;
            if (sample_now) begin
                rx_se0 <= se0;
            end
        end
    end
`else
    logic unused_se0_pins;

    assign unused_se0_pins = dp_i ^ dn_i;
    assign se0             = 1'b0;
    assign rx_se0          = 1'b0;
`endif

endmodule

// File: tb/tb_usb_dppl_cdr.sv
// Purpose : self-checking bench for usb_dppl_cdr (OVERSAMPLE=4, SYNC_STAGES=2, LOCK_EDGES=4, IDLE_BITS=8).
// Latency : reference model predicts every output one cycle ahead from elapsed time since the last edge.
// Backpr. : none; the bench drives one input sample per clk48 cycle.

module tb_usb_dppl_cdr;

    localparam int OS   = 4;
    localparam int LOCK = 4;
    localparam int IDLB = 8;
`ifdef USB_DPPL_SE0_DETECT_EN
    localparam bit SE0_EN = 1'b1;
`else
    localparam bit SE0_EN = 1'b0;
`endif

    logic clk48;
    logic RST;
    logic rxd;
    logic dp_i;
    logic dn_i;
    logic rx_bit;
    logic rx_valid;
    logic rx_se0;
    logic se0;
    logic locked;
    logic phase_err;

    usb_dppl_cdr dut (
        .clk48     (clk48),
        .RST       (RST),
        .rxd       (rxd),
        .dp_i      (dp_i),
        .dn_i      (dn_i),
        .rx_bit    (rx_bit),
        .rx_valid  (rx_valid),
        .rx_se0    (rx_se0),
        .se0       (se0),
        .locked    (locked),
        .phase_err (phase_err)
    );

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Reference model state: line history after the synchroniser delay,
    // time of the last accepted edge, and the run of in-window edges.
    logic d1, d2, sprev, p1, p2, n1, n2, lowd, trk;
    logic e_valid, e_bit, e_rxse0, e_se0, e_locked, e_perr;
    int   run, last_e, cyc_n;

    logic dp_v, dn_v, lv;
    int   strobes, perrs, se0_seen;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clk48 cycle: drive inputs, advance the model, clock, compare.
    task automatic cyc(input logic r, input logic d);
        logic s, le, low, inwin;
        int   ph, dt;
        RST  = r;
        rxd  = d;
        dp_i = dp_v;
        dn_i = dn_v;
        e_valid = 1'b0;
        e_perr  = 1'b0;
        if (r) begin
            trk = 0; run = 0; last_e = 0;
            e_bit = 0; e_rxse0 = 0; e_se0 = 0; e_locked = 0; lowd = 0;
            d1 = 0; d2 = 0; sprev = 0; p1 = 0; p2 = 0; n1 = 0; n2 = 0;
        end else begin
            s   = d2;
            low = SE0_EN && !p2 && !n2;
            le  = (s != sprev) && !e_se0;
            if (le) begin
                ph    = trk ? (cyc_n - last_e) % OS : 0;
                inwin = (ph == OS - 1) || (ph <= 1);
                if (inwin) begin
                    if (run < LOCK) run++;
                    if (run == LOCK) e_locked = 1'b1;
                end else begin
                    run      = 0;
                    e_locked = 1'b0;
                end
                e_perr = trk && (ph == OS / 2);
                trk    = 1'b1;
                last_e = cyc_n;
            end else if (trk) begin
                dt = cyc_n - last_e;
                if (dt % OS == OS / 2) begin
                    e_valid = 1'b1;
                    e_bit   = s;
                    e_rxse0 = e_se0;
                end
                if (dt + 1 == IDLB * OS) begin
                    trk      = 1'b0;
                    run      = 0;
                    e_locked = 1'b0;
                end
            end
            e_se0 = low && lowd;
            lowd  = low;
            sprev = s;
            d2 = d1; d1 = d;
            p2 = p1; p1 = dp_v;
            n2 = n1; n1 = dn_v;
        end
        cyc_n++;
        @(posedge clk48);
        #1;
        chk("rx_valid",  rx_valid,  e_valid);
        chk("rx_bit",    rx_bit,    e_bit);
        chk("rx_se0",    rx_se0,    e_rxse0);
        chk("se0",       se0,       e_se0);
        chk("locked",    locked,    e_locked);
        chk("phase_err", phase_err, e_perr);
        if (rx_valid)  strobes++;
        if (phase_err) perrs++;
        if (se0)       se0_seen++;
    endtask

    task automatic send(input logic lvl, input int per);
        for (int i = 0; i < per; i++) cyc(1'b0, lvl);
    endtask

    initial begin
        RST = 1'b1; rxd = 1'b1; dp_i = 1'b1; dn_i = 1'b0;
        dp_v = 1'b1; dn_v = 1'b0;
        cyc_n = 0; strobes = 0; perrs = 0; se0_seen = 0;

        // Reset with rxd toggling: everything stays 0.
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_locked",   locked,   1'b0);

        // Idle J; the step out of the cleared synchroniser starts tracking,
        // which then times out.
        send(1'b1, 40);
        chk("post_reset_idle_locked", locked, 1'b0);

        // Sync pattern KJKJKJKJ at the nominal rate.
        lv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lv = ~lv;
            send(lv, 4);
        end
        chk("locked_after_sync", locked, 1'b1);

        // Slow drift: three bits of 5 cycles.
        for (int i = 0; i < 3; i++) begin
            lv = ~lv;
            send(lv, 5);
        end
        chk("locked_after_drift", locked, 1'b1);

        // Glitch 2 cycles after a transition.
        for (int i = 0; i < 6; i++) begin
            lv = ~lv;
            send(lv, 4);
        end
        perrs = 0;
        lv = ~lv;
        send(lv, 2);
        lv = ~lv;
        send(lv, 4);
        chk_int("glitch_phase_err", perrs, 1);
        chk("glitch_unlock", locked, 1'b0);

        // Relock, then hold the line for 36 cycles.
        for (int i = 0; i < 6; i++) begin
            lv = ~lv;
            send(lv, 4);
        end
        chk("relock", locked, 1'b1);
        lv = ~lv;
        send(lv, 2);
        strobes = 0;
        send(lv, 34);
        chk_int("hold_strobes", strobes, IDLB);
        chk("hold_unlock", locked, 1'b0);
        strobes = 0;
        send(lv, 8);
        chk_int("idle_no_strobes", strobes, 0);

        // Restart from IDLE and run a packet with an SE0 interval.
        for (int i = 0; i < 6; i++) begin
            lv = ~lv;
            send(lv, 4);
        end
        dp_v = 1'b0; dn_v = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1'b0, i[0] ^ lv);
        dp_v = 1'b1; dn_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lv = ~lv;
            send(lv, 4);
        end
`ifdef USB_DPPL_SE0_DETECT_EN
        chk("se0_observed", (se0_seen > 0), 1'b1);
`endif

        // Randomised traffic: jittered periods, runs, glitches, long holds.
        for (int i = 0; i < 80; i++) begin
            int per;
            int pick;
            per  = $urandom_range(3, 5);
            pick = $urandom_range(0, 19);
            lv   = ~lv;
            if (pick < 2) begin
                send(lv, $urandom_range(1, 3));
                lv = ~lv;
                send(lv, per);
            end else if (pick == 2) begin
                send(lv, 40);
            end else if (pick == 3) begin
                dp_v = 1'b0; dn_v = 1'b0;
                send(lv, $urandom_range(2, 9));
                dp_v = 1'b1;
                send(lv, per);
            end else begin
                send(lv, per * $urandom_range(1, 3));
            end
        end

        // Reset mid-packet drops any pending strobe.
        for (int i = 0; i < 6; i++) begin
            lv = ~lv;
            send(lv, 4);
        end
        lv = ~lv;
        send(lv, 2);
        cyc(1'b1, lv);
        chk("midreset_no_strobe", rx_valid, 1'b0);
        chk("midreset_unlocked", locked, 1'b0);
        for (int i = 0; i < 10; i++) begin
            lv = ~lv;
            send(lv, 4);
        end
        chk("locked_after_midreset", locked, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
